// File: rtl/muldiv_unit_if.sv
// ============================================================================
// Module : muldiv_unit_if
// Purpose: Issue/result bundle between the EX stage and the mult/div unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, hi, lo
  );
endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module : muldiv_unit
// Purpose: Multi-cycle mult/div with architectural HI/LO and a busy interlock.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  wire logic     clk,
  input  wire logic     reset,
  muldiv_unit_if.slave  bus
);

  localparam int c_MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int c_CNT_W   = $clog2(c_MAX_LAT + 1);

  localparam logic [c_CNT_W-1:0] c_MUL_CNT = c_CNT_W'(MUL_LAT);
  localparam logic [c_CNT_W-1:0] c_DIV_CNT = c_CNT_W'(DIV_LAT);

  localparam logic [2:0] c_OP_MULT  = 3'd0;
  localparam logic [2:0] c_OP_MULTU = 3'd1;
  localparam logic [2:0] c_OP_DIV   = 3'd2;
  localparam logic [2:0] c_OP_DIVU  = 3'd3;
  localparam logic [2:0] c_OP_MTHI  = 3'd4;
  localparam logic [2:0] c_OP_MTLO  = 3'd5;

  localparam logic [WIDTH-1:0] c_MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] c_ALL_ONE = {WIDTH{1'b1}};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_pend_hi;
  logic [WIDTH-1:0]   r_pend_lo;
  logic               r_pend_valid;

  logic w_launch;
  logic w_finish;
  logic w_mthi;
  logic w_mtlo;

  // ---------------------------------------------------------------------------
  // Arithmetic, evaluated on the issue cycle only
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0]        w_a_zx;
  logic [2*WIDTH-1:0]        w_b_zx;
  logic signed [2*WIDTH-1:0] w_a_sx;
  logic signed [2*WIDTH-1:0] w_b_sx;
  logic [2*WIDTH-1:0]        w_prod_u;
  logic signed [2*WIDTH-1:0] w_prod_s;

  assign w_a_zx   = {{WIDTH{1'b0}}, bus.a};
  assign w_b_zx   = {{WIDTH{1'b0}}, bus.b};
  assign w_a_sx   = {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
  assign w_b_sx   = {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
  assign w_prod_u = w_a_zx * w_b_zx;
  assign w_prod_s = w_a_sx * w_b_sx;

  logic                    w_div_zero;
  logic                    w_div_ovf;
  logic [WIDTH-1:0]        w_b_safe;
  logic signed [WIDTH-1:0] w_sa;
  logic signed [WIDTH-1:0] w_sb;
  logic signed [WIDTH-1:0] w_quo_s;
  logic signed [WIDTH-1:0] w_rem_s;
  logic [WIDTH-1:0]        w_quo_u;
  logic [WIDTH-1:0]        w_rem_u;

  // A zero divisor is swapped for 1 so the divider never sees x/0; the
  // result is discarded anyway through r_pend_valid.
  assign w_div_zero = (bus.b == '0);
  assign w_div_ovf  = (bus.a == c_MIN_NEG) && (bus.b == c_ALL_ONE);
  assign w_b_safe   = w_div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : bus.b;
  assign w_sa       = $signed(bus.a);
  assign w_sb       = $signed(w_b_safe);
  assign w_quo_s    = w_sa / w_sb;
  assign w_rem_s    = w_sa % w_sb;
  assign w_quo_u    = bus.a / w_b_safe;
  assign w_rem_u    = bus.a % w_b_safe;

  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;

  always_comb begin
    w_res_hi = '0;
    w_res_lo = '0;
    case (bus.op)
      c_OP_MULT: begin
        w_res_hi = w_prod_s[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod_s[WIDTH-1:0];
      end
      c_OP_MULTU: begin
        w_res_hi = w_prod_u[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod_u[WIDTH-1:0];
      end
      c_OP_DIV: begin
        if (w_div_ovf) begin
          w_res_hi = '0;
          w_res_lo = c_MIN_NEG;
        end else begin
          w_res_hi = w_rem_s;
          w_res_lo = w_quo_s;
        end
      end
      c_OP_DIVU: begin
        w_res_hi = w_rem_u;
        w_res_lo = w_quo_u;
      end
      default: begin
        w_res_hi = '0;
        w_res_lo = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_finish    = 1'b0;
    w_mthi      = 1'b0;
    w_mtlo      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            c_OP_MULT, c_OP_MULTU, c_OP_DIV, c_OP_DIVU: begin
              w_launch    = 1'b1;
              w_state_nxt = S_BUSY;
            end
            c_OP_MTHI: w_mthi = 1'b1;
            c_OP_MTLO: w_mtlo = 1'b1;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        // Every start in this state is dropped; hazard logic stalls instead.
        if (r_cnt <= c_CNT_W'(1)) begin
          w_finish    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counter, pending result and HI/LO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_hi         <= '0;
      r_lo         <= '0;
      r_pend_hi    <= '0;
      r_pend_lo    <= '0;
      r_pend_valid <= 1'b0;
    end else begin
      if (w_launch) begin
        r_cnt        <= bus.op[1] ? c_DIV_CNT : c_MUL_CNT;
        r_pend_hi    <= w_res_hi;
        r_pend_lo    <= w_res_lo;
        r_pend_valid <= !(bus.op[1] && w_div_zero);
      end else if (r_state == S_BUSY) begin
        r_cnt <= r_cnt - c_CNT_W'(1);
      end

      if (w_finish && r_pend_valid) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
      if (w_mthi) begin
        r_hi <= bus.a;
      end
      if (w_mtlo) begin
        r_lo <= bus.a;
      end
    end
  end

  assign bus.busy = (r_state == S_BUSY);
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

`default_nettype wire
